// File: rtl/abl_pkg.sv
// Shared encodings for the address-bus-low unit.
// Base/offset select codes used by abl_unit and its bench.
package abl_pkg;

  localparam logic [1:0] BASE_PCL  = 2'b00;
  localparam logic [1:0] BASE_ABL  = 2'b01;
  localparam logic [1:0] BASE_AHL  = 2'b10;
  localparam logic [1:0] BASE_ZERO = 2'b11;

  localparam logic [1:0] OFF_ZERO = 2'b00;
  localparam logic [1:0] OFF_REG  = 2'b01;
  localparam logic [1:0] OFF_DB   = 2'b10;
  localparam logic [1:0] OFF_COND = 2'b11;

  localparam logic [7:0] BYTE_ZERO = 8'h00;
  localparam logic [7:0] BYTE_MAX  = 8'hFF;

  function automatic logic [7:0] gate_byte(
    input logic       en,
    input logic [7:0] val
  );
    return en ? val : BYTE_ZERO;
  endfunction

endpackage

// File: rtl/abl_add8.sv
// 8-bit adder with carry-in and carry-out.
// Purely combinational; sum wraps modulo 256.
module abl_add8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] sum,
  output logic       co
);

  logic [8:0] wide;

  assign wide = {1'b0, a} + {1'b0, b} + {8'b0, ci};
  assign sum  = wide[7:0];
  assign co   = wide[8];

endmodule

// File: rtl/abl_unit.sv
// Address-bus-low unit: base+offset adder, ABL/AHL/PCL registers.
// Optional macro ABL_COND_OFFSET_EN gates offset code 11 with cond.
module abl_unit
  import abl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       rdy,
  input  logic [3:0] op,
  input  logic       CI,
  output logic       CO,
  input  logic       cond,
  input  logic       ld_ahl,
  input  logic       ld_pc,
  input  logic       inc_pc,
  output logic       pcl_co,
  output logic [7:0] PCL,
  output logic [7:0] ADL,
  input  logic [7:0] DB,
  input  logic [7:0] REG
);

  logic [7:0] pcl_q;
  logic [7:0] abl_q;
  logic [7:0] ahl_q;
  logic [7:0] base;
  logic [7:0] offset;
  logic [7:0] off_cond;
  logic [7:0] pcl_src;
  logic [7:0] pcl_next;

`ifdef ABL_COND_OFFSET_EN
  assign off_cond = gate_byte(cond, DB);
`else
  logic unused_cond;
  assign unused_cond = cond;
  assign off_cond    = DB;
`endif

  always_comb begin
    base = BYTE_ZERO;
    unique case (op[3:2])
      BASE_PCL:  base = pcl_q;
      BASE_ABL:  base = abl_q;
      BASE_AHL:  base = ahl_q;
      BASE_ZERO: base = BYTE_ZERO;
    endcase
  end

  always_comb begin
    offset = BYTE_ZERO;
    unique case (op[1:0])
      OFF_ZERO: offset = BYTE_ZERO;
      OFF_REG:  offset = REG;
      OFF_DB:   offset = DB;
      OFF_COND: offset = off_cond;
    endcase
  end

  abl_add8 u_add (
    .a   (base),
    .b   (offset),
    .ci  (CI),
    .sum (ADL),
    .co  (CO)
  );

  // One incrementer serves both the load+inc and the plain inc paths.
  assign pcl_src  = ld_pc ? ADL : pcl_q;
  assign pcl_next = pcl_src + {7'b0, inc_pc};
  assign pcl_co   = inc_pc & (pcl_src == BYTE_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      pcl_q <= BYTE_ZERO;
      abl_q <= BYTE_ZERO;
      ahl_q <= BYTE_ZERO;
    end else if (rdy) begin
      abl_q <= ADL;
      pcl_q <= pcl_next;
      if (ld_ahl)
        ahl_q <= DB;
    end
  end

  assign PCL = pcl_q;

endmodule

// File: tb/tb_abl_unit.sv
// Self-checking bench for abl_unit: directed cases plus random
// stimulus against a behavioural model of PCL/ABL/AHL.
module tb_abl_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rdy = 1'b1;
  logic [3:0] op = 4'h0;
  logic       ci = 1'b0;
  logic       co;
  logic       cond = 1'b0;
  logic       ld_ahl = 1'b0;
  logic       ld_pc = 1'b0;
  logic       inc_pc = 1'b0;
  logic       pcl_co;
  logic [7:0] pcl;
  logic [7:0] adl;
  logic [7:0] db = 8'h00;
  logic [7:0] rg = 8'h00;

  int n_cmp = 0;
  int n_bad = 0;
  int m_pcl = 0;
  int m_abl = 0;
  int m_ahl = 0;

  abl_unit dut (
    .clk    (clk),
    .reset  (reset),
    .rdy    (rdy),
    .op     (op),
    .CI     (ci),
    .CO     (co),
    .cond   (cond),
    .ld_ahl (ld_ahl),
    .ld_pc  (ld_pc),
    .inc_pc (inc_pc),
    .pcl_co (pcl_co),
    .PCL    (pcl),
    .ADL    (adl),
    .DB     (db),
    .REG    (rg)
  );

  always #5 clk = ~clk;

`ifdef ABL_COND_OFFSET_EN
  localparam bit COND_EN = 1'b1;
`else
  localparam bit COND_EN = 1'b0;
`endif

  function automatic int model_sum();
    int b;
    int o;
    case (op[3:2])
      2'd0:    b = m_pcl;
      2'd1:    b = m_abl;
      2'd2:    b = m_ahl;
      default: b = 0;
    endcase
    case (op[1:0])
      2'd0:    o = 0;
      2'd1:    o = int'(rg);
      2'd2:    o = int'(db);
      default: o = (COND_EN && !cond) ? 0 : int'(db);
    endcase
    return b + o + int'(ci);
  endfunction

  function automatic int model_pcl_co();
    int src;
    src = ld_pc ? model_sum() % 256 : m_pcl;
    return (inc_pc && src == 255) ? 1 : 0;
  endfunction

  task automatic clock_model();
    int a;
    int np;
    int nb;
    int nh;
    a  = model_sum() % 256;
    np = m_pcl;
    nb = m_abl;
    nh = m_ahl;
    if (reset) begin
      np = 0;
      nb = 0;
      nh = 0;
    end else if (rdy) begin
      nb = a;
      if (ld_ahl) nh = int'(db);
      if (ld_pc) np = (a + int'(inc_pc)) % 256;
      else if (inc_pc) np = (m_pcl + 1) % 256;
    end
    @(posedge clk);
    m_pcl = np;
    m_abl = nb;
    m_ahl = nh;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rdy = 1'b1;
    ld_ahl = 1'b1;
    ld_pc = 1'b1;
    inc_pc = 1'b1;
    db = 8'h5A;
    op = 4'b1110;
    clock_model();
    reset = 1'b0;
    ld_ahl = 1'b0;
    ld_pc = 1'b0;
    inc_pc = 1'b0;
    op = 4'b0000;
    ci = 1'b0;
    #1;
    n_cmp++;
    if (pcl !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_pcl got %h want 00", pcl);
    end
    n_cmp++;
    if (adl !== 8'h00 || co !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_adl got %h/%b want 00/0", adl, co);
    end
    op = 4'b1000;
    #1;
    n_cmp++;
    if (adl !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_ahl got %h want 00", adl);
    end
  endtask

  task automatic test_pcl_wrap();
    op = 4'b1110;
    db = 8'hFF;
    ci = 1'b0;
    ld_pc = 1'b1;
    inc_pc = 1'b0;
    clock_model();
    ld_pc = 1'b0;
    inc_pc = 1'b1;
    #1;
    n_cmp++;
    if (pcl !== 8'hFF || pcl_co !== 1'b1) begin
      n_bad++;
      $display("FAIL pcl_co got %h/%b want FF/1", pcl, pcl_co);
    end
    clock_model();
    inc_pc = 1'b0;
    #1;
    n_cmp++;
    if (pcl !== 8'h00 || pcl_co !== 1'b0) begin
      n_bad++;
      $display("FAIL pcl_wrap got %h/%b want 00/0", pcl, pcl_co);
    end
  endtask

  task automatic test_ahl_index();
    db = 8'h80;
    ld_ahl = 1'b1;
    op = 4'b0000;
    clock_model();
    ld_ahl = 1'b0;
    db = 8'h33;
    rg = 8'h90;
    op = 4'b1001;
    ci = 1'b0;
    #1;
    n_cmp++;
    if (adl !== 8'h10 || co !== 1'b1) begin
      n_bad++;
      $display("FAIL ahl_idx got %h/%b want 10/1", adl, co);
    end
    clock_model();
    op = 4'b0100;
    #1;
    n_cmp++;
    if (adl !== 8'h10 || co !== 1'b0) begin
      n_bad++;
      $display("FAIL abl_reg got %h/%b want 10/0", adl, co);
    end
  endtask

  task automatic test_cond();
    logic [7:0] want;
    op = 4'b1110;
    db = 8'h20;
    ci = 1'b0;
    ld_pc = 1'b1;
    inc_pc = 1'b0;
    clock_model();
    ld_pc = 1'b0;
    op = 4'b0011;
    db = 8'h05;
    cond = 1'b1;
    #1;
    n_cmp++;
    if (adl !== 8'h25) begin
      n_bad++;
      $display("FAIL cond1 got %h want 25", adl);
    end
    cond = 1'b0;
    want = COND_EN ? 8'h20 : 8'h25;
    #1;
    n_cmp++;
    if (adl !== want) begin
      n_bad++;
      $display("FAIL cond0 got %h want %h", adl, want);
    end
    cond = 1'b1;
    ld_pc = 1'b1;
    inc_pc = 1'b1;
    clock_model();
    ld_pc = 1'b0;
    inc_pc = 1'b0;
    #1;
    n_cmp++;
    if (pcl !== 8'h26) begin
      n_bad++;
      $display("FAIL ld_inc got %h want 26", pcl);
    end
  endtask

  task automatic test_freeze();
    int pre_pcl;
    int pre_abl;
    int pre_ahl;
    pre_pcl = m_pcl;
    pre_abl = m_abl;
    pre_ahl = m_ahl;
    rdy = 1'b0;
    ld_ahl = 1'b1;
    ld_pc = 1'b1;
    inc_pc = 1'b1;
    db = ~8'(pre_ahl);
    rg = 8'($urandom);
    op = 4'b0101;
    ci = 1'b1;
    #1;
    n_cmp++;
    if (adl !== 8'(model_sum()) || co !== 1'(model_sum() / 256)) begin
      n_bad++;
      $display("FAIL frz_adl got %h/%b want %h", adl, co, model_sum());
    end
    clock_model();
    n_cmp++;
    if (pcl !== 8'(pre_pcl)) begin
      n_bad++;
      $display("FAIL frz_pcl got %h want %h", pcl, pre_pcl);
    end
    op = 4'b1000;
    ci = 1'b0;
    #1;
    n_cmp++;
    if (adl !== 8'(pre_ahl)) begin
      n_bad++;
      $display("FAIL frz_ahl got %h want %h", adl, pre_ahl);
    end
    op = 4'b0100;
    #1;
    n_cmp++;
    if (adl !== 8'(pre_abl)) begin
      n_bad++;
      $display("FAIL frz_abl got %h want %h", adl, pre_abl);
    end
    rdy = 1'b1;
    ld_ahl = 1'b0;
    ld_pc = 1'b0;
    inc_pc = 1'b0;
  endtask

  task automatic test_zero_base();
    op = 4'b1100;
    ci = 1'b1;
    db = 8'($urandom);
    rg = 8'($urandom);
    #1;
    n_cmp++;
    if (adl !== 8'h01 || co !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_base got %h/%b want 01/0", adl, co);
    end
    ld_pc = 1'b1;
    clock_model();
    ld_pc = 1'b0;
    ci = 1'b0;
    #1;
    n_cmp++;
    if (pcl !== 8'h01) begin
      n_bad++;
      $display("FAIL zero_ldpc got %h want 01", pcl);
    end
  endtask

  task automatic test_random();
    int s;
    for (int i = 0; i < 300; i++) begin
      reset = ($urandom_range(0, 24) == 0);
      rdy = ($urandom_range(0, 4) != 0);
      op = 4'($urandom);
      ci = 1'($urandom);
      cond = 1'($urandom);
      ld_ahl = 1'($urandom);
      ld_pc = 1'($urandom);
      inc_pc = 1'($urandom);
      db = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      rg = 8'($urandom);
      #1;
      s = model_sum();
      n_cmp++;
      if (adl !== 8'(s % 256) || co !== 1'(s / 256)) begin
        n_bad++;
        $display("FAIL rnd_adl i=%0d got %h/%b want %h/%0d",
                 i, adl, co, s % 256, s / 256);
      end
      n_cmp++;
      if (pcl_co !== 1'(model_pcl_co())) begin
        n_bad++;
        $display("FAIL rnd_pclco i=%0d got %b want %0d",
                 i, pcl_co, model_pcl_co());
      end
      clock_model();
      n_cmp++;
      if (pcl !== 8'(m_pcl)) begin
        n_bad++;
        $display("FAIL rnd_pcl i=%0d got %h want %h", i, pcl, m_pcl);
      end
    end
    reset = 1'b0;
    rdy = 1'b1;
  endtask

  initial begin
    #1;
    test_reset();
    test_pcl_wrap();
    test_ahl_index();
    test_cond();
    test_freeze();
    test_zero_base();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/abl_unit.md
ABL_UNIT -- requirements
Module: abl

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: rdy  in  1  advance enable; 0 freezes all registers.
REQ-004 SHALL have ports: op  in  4  address-low operation; op[3:2] base select, op[1:0] offset select.
REQ-005 SHALL have ports: CI  in  1  adder carry-in.
REQ-006 SHALL have ports: CO  out  1  adder carry-out, combinational.
REQ-007 SHALL have ports: cond  in  1  branch condition, gates offset code 11.
REQ-008 SHALL have ports: ld_ahl  in  1  load AHL hold register from DB.
REQ-009 SHALL have ports: ld_pc  in  1  load PCL from ADL.
REQ-010 SHALL have ports: inc_pc  in  1  increment PCL.
REQ-011 SHALL have ports: pcl_co  out  1  PCL increment carry, combinational.
REQ-012 SHALL have ports: PCL  out  8  program counter low register.
REQ-013 SHALL have ports: ADL  out  8  address bus low, combinational.
REQ-014 SHALL have ports: DB  in  8  data bus input.
REQ-015 SHALL have ports: REG  in  8  register-file output (index value).

Function
REQ-016 SHALL compute {CO, ADL} = base + offset + CI, unsigned 9-bit sum, all combinational.
REQ-017 SHALL select base from op[3:2]: 00 PCL, 01 ABL (previous ADL), 10 AHL, 11 8'h00.
REQ-018 SHALL select offset from op[1:0]: 00 8'h00, 01 REG, 10 DB, 11 (cond ? DB : 8'h00).
REQ-019 SHALL register ABL <= ADL every cycle with rdy=1.
REQ-020 SHALL register AHL <= DB when ld_ahl=1 and rdy=1, else hold.
REQ-021 SHALL update PCL when rdy=1: ld_pc=1 -> ADL + inc_pc; ld_pc=0, inc_pc=1 -> PCL + 1; else hold; wraps FF->00.
REQ-022 SHALL drive pcl_co = inc_pc & (src == 8'hFF), where src = ld_pc ? ADL : PCL.
REQ-023 SHALL produce pcl_co and CO regardless of rdy; with rdy=0, ADL still follows the inputs, but no register changes.
REQ-024 SHALL wrap the ADL sum modulo 256 and report the overflow only on CO, e.g. FF+01+0 -> ADL 00, CO 1.
REQ-025 SHALL apply ld_pc and inc_pc together in one cycle as specified in REQ-021, with no extra latency.

Reset
REQ-026 SHALL clear PCL, ABL and AHL to 8'h00 on the clock edge where reset=1, overriding rdy, ld_pc, inc_pc and ld_ahl.
REQ-027 SHALL compute outputs from the cleared registers in the cycle following reset: op=0000, CI=0 -> ADL 00, CO 0.

Configuration
REQ-028 SHALL honour macro ABL_COND_OFFSET_EN: defined -> offset code 11 is (cond ? DB : 00); undefined -> code 11 is DB unconditionally, and cond is ignored.

Structure
REQ-029 SHALL take the base-select and offset-select encodings, as named localparams, from shared package abl_pkg.
REQ-030 SHALL implement the 8-bit add with carry-in/out as one sub-module, abl_add8; the muxes and registers stay in abl.

Verification
REQ-031 SHALL cover: reset=1, then op=0000, CI=0 -> PCL 00, ADL 00, CO 0.
REQ-032 SHALL cover: PCL=FF, inc_pc=1, ld_pc=0 -> pcl_co 1 combinationally; next PCL 00.
REQ-033 SHALL cover: AHL loaded with 80 via DB, REG=90, op=1001, CI=0 -> ADL 10, CO 1; next ABL 10.
REQ-034 SHALL cover: PCL=20, DB=05, op=0011, cond=1 -> ADL 25; with cond=0 -> ADL 20; ld_pc=1, inc_pc=1, cond=1 -> next PCL 26.
REQ-035 SHALL cover: rdy=0 with ld_ahl=1, ld_pc=1, inc_pc=1 -> PCL, AHL and ABL unchanged, while ADL still tracks the inputs.
REQ-036 SHALL cover: op=1100, CI=1 -> ADL 01, CO 0; ld_pc=1 -> next PCL 01.
